uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
// - UART 8N1 receiver on hwclk; serial rx pin -> one byte per frame on a valid/ready port.
// - Sits upstream of the LED command/decoder stage: that stage consumes bytes ("1".."5") to toggle LEDs.
// - Holds one byte in an output register; reports framing errors and overruns as 1-cycle pulses.
// PARAMETERS
// - CLOCK_FREQ_HZ  12000000  hwclk frequency in Hz.
// - BAUD_RATE      9600      serial bit rate.
// - HALF_PERIOD (localparam) = CLOCK_FREQ_HZ/(2*BAUD_RATE), 625 at defaults; a bit period is 2*HALF_PERIOD clocks.
// PORTS
// - hwclk       in   1  sole clock, rising edge.
// - rst         in   1  asynchronous, active-high reset.
// - rx          in   1  async serial input, idle high.
// - data_out    out  8  received byte, LSB first on the wire; stable while data_valid=1.
// - data_valid  out  1  data_out holds an unconsumed byte.
// - data_ready  in   1  consumer accepts; transfer happens on a cycle with data_valid&&data_ready.
// - frame_err   out  1  1-cycle pulse: stop bit sampled low, byte discarded.
// - overrun     out  1  1-cycle pulse: good byte arrived while the holding register was full and not being accepted.
// - busy        out  1  FSM not in IDLE.
// BEHAVIOUR
// - Reset: state=IDLE, both sync flops=1, cnt=0, bit_idx=0, shift=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
// - rx passes through a 2-flop synchronizer (rx_s); the FSM uses only rx_s. This adds 2 cycles of latency.
// - cnt width: $clog2(2*HALF_PERIOD) bits. Counts 0..2*HALF_PERIOD-1; it never wraps in any other way.
// - IDLE: when rx_s==0, go to START with cnt=0.
// - START: at cnt==HALF_PERIOD-1, sample rx_s (mid start bit).
//   - 0: go to DATA with cnt=0 and bit_idx=0.
//   - 1: glitch; go to IDLE. No pulse.
// - DATA: at cnt==2*HALF_PERIOD-1, shift = {rx_s, shift[7:1]} and cnt=0.
//   - After bit_idx==7 is sampled, go to STOP; otherwise bit_idx+1.
// - STOP: at cnt==2*HALF_PERIOD-1, sample rx_s.
//   - 1: deliver the byte and go to IDLE.
//   - 0: frame_err=1 for one cycle; go to BREAK.
// - BREAK: wait for rx_s==1, then go to IDLE. A held-low line never retriggers reception.
// - Deliver, on the cycle after the stop sample:
//   - If !data_valid, or data_valid&&data_ready in the stop-sample cycle: data_out=shift, data_valid=1.
//   - Else: overrun=1 for one cycle; the new byte is dropped and the held byte and data_valid are unchanged.
// - A handshake with no simultaneous delivery clears data_valid on the next cycle.
// - Simultaneous accept and delivery: the new byte loads; data_valid stays 1 with no gap.
// - data_ready is ignored while data_valid=0.
// - Frame latency: rx falling edge to data_valid rise = 2 + 1 + 19*HALF_PERIOD + 1 clocks (+/-1 for edge alignment).
// - rst asserted mid-frame: immediate return to reset values; the partial byte is lost; the held byte is cleared.
// - busy=1 in START, DATA, STOP and BREAK.
// STRUCTURE
// - Package uart_pkg:
//   - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK}.
//   - function half_period(clk_hz, baud).
// - Sub-module sync_2ff (hwclk, rst, d, q; reset value parameter RST_VAL=1), reusable for other pin inputs.
// - Remainder: one FSM/counter always block plus one holding-register always block.
// TESTING
// - Sim parameters: CLOCK_FREQ_HZ=160, BAUD_RATE=10 (HALF_PERIOD=8, 16 clocks/bit); bench drives rx at 16 clocks/bit.
// - Send 0x31 with data_ready=1:
//   - data_out=8'h31 with exactly one data_valid cycle.
//   - Rise lands 155+/-1 clocks after the rx fall.
//   - No frame_err, no overrun.
// - Send 0xA5 then 0x5A with data_ready=0:
//   - After 0xA5: data_out=8'hA5, data_valid=1.
//   - At 0x5A's stop: one overrun pulse; data_out stays 8'hA5.
//   - Raise data_ready: data_valid=0 on the next cycle.
// - Send 0x55 with the stop bit forced to 0, then hold rx low 40 clocks:
//   - One frame_err pulse, data_valid stays 0, busy=1 until rx returns high.
//   - A following 0x33 is received correctly.
// - 4-clock low glitch on idle rx: FSM returns to IDLE from START; no data_valid, no pulses.
// - Two back-to-back frames 0x01, 0x02 with data_ready pulsed exactly on the cycle the 0x02 load occurs:
//   - data_valid stays high continuously; data_out changes 8'h01 -> 8'h02.
// - Assert rst during bit 4 of a frame:
//   - All outputs return to 0 asynchronously.
//   - The next complete frame 0xC3 is received.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// Shared types and helpers for the UART byte receiver.
package uart_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks per half bit period; a full bit lasts twice this.
    function automatic int half_period(input int clk_hz, input int baud);
        return clk_hz / (2 * baud);
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte output port of the UART receiver: valid/ready handshake plus status pulses.
interface uart_rx_byte_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    // Receiver side drives the byte and status.
    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output busy,
        input  data_ready
    );

    // Consumer side accepts bytes.
    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin input.
module sync_2ff #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic hwclk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply shift the pin down the chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, preset to the idle level of the pin.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: serial rx -> one byte per frame on a valid/ready port,
// with one-byte holding register and framing-error / overrun pulses.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE     = 9600
) (
    input  logic           hwclk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_byte_if.master bus
);
    localparam int HALF_PERIOD = half_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int BIT_PERIOD  = 2 * HALF_PERIOD;
    localparam int CNT_W       = $clog2(BIT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_PERIOD - 1);

    logic rx_s;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_good;
    logic             stop_bad;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       accept;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .hwclk (hwclk),
        .rst   (rst),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: find the start bit, sample mid-bit, check the stop bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    // Still low at mid start bit means a real frame; high was a glitch.
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must go high before another frame can start.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM / counter / shift register state.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    assign accept = valid_q && bus.data_ready;

    // Holding register: load on a good stop bit if free or being emptied, else flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = stop_bad;
        ovr_d   = 1'b0;
        if (accept) valid_d = 1'b0;
        if (stop_good) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Holding register and status pulse flops.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;
    localparam int LAT = 155;   // rx fall to data_valid rise, in clocks

    logic hwclk = 1'b0;
    logic rst   = 1'b1;
    logic rx    = 1'b1;

    uart_rx_byte_if bus_if ();

    uart_rx_byte #(
        .CLOCK_FREQ_HZ (160),
        .BAUD_RATE     (10)
    ) dut (
        .hwclk (hwclk),
        .rst   (rst),
        .rx    (rx),
        .bus   (bus_if.master)
    );

    always #5 hwclk = ~hwclk;

    int errors = 0;
    int checks = 0;

    // Free-running cycle count: after posedge k, cyc == k.
    int cyc = 0;
    always @(posedge hwclk) cyc <= cyc + 1;

    // Frame requests posted by the stimulus.
    int         tx_req_cnt = 0;
    logic [7:0] tx_byte    = 8'h00;
    logic       tx_ok      = 1'b1;

    // Behavioural model: each frame resolves LAT clocks after its start bit.
    int         ev_due[$];
    logic [7:0] ev_byte[$];
    logic       ev_ok[$];
    int         seen_req = 0;
    logic       m_valid  = 1'b0;
    logic [7:0] m_data   = 8'h00;
    logic       m_ovr    = 1'b0;
    logic       m_ferr   = 1'b0;

    always @(posedge hwclk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_ovr   <= 1'b0;
            m_ferr  <= 1'b0;
            ev_due.delete();
            ev_byte.delete();
            ev_ok.delete();
            seen_req <= tx_req_cnt;
        end else begin
            if (ev_due.size() > 0 && ev_due[0] == cyc + 1) begin
                if (ev_ok[0]) begin
                    if (!m_valid || bus_if.data_ready) begin
                        m_valid <= 1'b1;
                        m_data  <= ev_byte[0];
                    end
                    m_ovr  <= m_valid && !bus_if.data_ready;
                    m_ferr <= 1'b0;
                end else begin
                    m_ferr <= 1'b1;
                    m_ovr  <= 1'b0;
                    if (m_valid && bus_if.data_ready) m_valid <= 1'b0;
                end
                void'(ev_due.pop_front());
                void'(ev_byte.pop_front());
                void'(ev_ok.pop_front());
            end else begin
                m_ovr  <= 1'b0;
                m_ferr <= 1'b0;
                if (m_valid && bus_if.data_ready) m_valid <= 1'b0;
            end
            if (tx_req_cnt != seen_req) begin
                ev_due.push_back(cyc + LAT);
                ev_byte.push_back(tx_byte);
                ev_ok.push_back(tx_ok);
                seen_req <= tx_req_cnt;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge hwclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        tx_byte = b;
        tx_ok   = stop_bit;
        tx_req_cnt++;
        rx = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(16);
        end
        rx = stop_bit;
        wait_clks(16);
    endtask

    // Monitor tallies (written only by the monitor thread).
    int dv_cnt    = 0;
    int dv_fall   = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int last_rise = 0;
    logic dv_prev = 1'b0;

    initial begin
        int t0, n2, lat;
        int dv0, fe0, ov0, fall0;
        bus_if.data_ready = 1'b0;

        wait_clks(3);
        check("reset_valid", bus_if.data_valid, 1'b0);
        check("reset_data",  bus_if.data_out,   8'h00);
        check("reset_ferr",  bus_if.frame_err,  1'b0);
        check("reset_ovr",   bus_if.overrun,    1'b0);
        check("reset_busy",  bus_if.busy,       1'b0);

        fork
            forever begin
                @(negedge hwclk);
                check("cyc_valid", bus_if.data_valid, m_valid);
                check("cyc_data",  bus_if.data_out,   m_data);
                check("cyc_ferr",  bus_if.frame_err,  m_ferr);
                check("cyc_ovr",   bus_if.overrun,    m_ovr);
                if (bus_if.data_valid) dv_cnt++;
                if (bus_if.data_valid && !dv_prev) last_rise = cyc;
                if (!bus_if.data_valid && dv_prev) dv_fall++;
                if (bus_if.frame_err) fe_cnt++;
                if (bus_if.overrun) ov_cnt++;
                dv_prev = bus_if.data_valid;
            end
        join_none

        rst = 1'b0;
        wait_clks(10);

        // 0x31 with consumer always ready
        bus_if.data_ready = 1'b1;
        dv0 = dv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        t0 = cyc;
        send_frame(8'h31, 1'b1);
        wait_clks(5);
        lat = last_rise - t0;
        check("latency_155pm1", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
        check("b31_data",     bus_if.data_out, 8'h31);
        check("b31_dv_cycles", dv_cnt - dv0, 1);
        check("b31_no_ferr",  fe_cnt - fe0, 0);
        check("b31_no_ovr",   ov_cnt - ov0, 0);

        // 0xA5 then 0x5A with consumer stalled
        bus_if.data_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        wait_clks(10);
        check("a5_data",  bus_if.data_out,   8'hA5);
        check("a5_valid", bus_if.data_valid, 1'b1);
        ov0 = ov_cnt;
        send_frame(8'h5A, 1'b1);
        wait_clks(5);
        check("ovr_pulses",    ov_cnt - ov0, 1);
        check("ovr_data_kept", bus_if.data_out, 8'hA5);
        check("ovr_valid",     bus_if.data_valid, 1'b1);
        bus_if.data_ready = 1'b1;
        wait_clks(1);
        check("accept_clears", bus_if.data_valid, 1'b0);
        bus_if.data_ready = 1'b0;
        wait_clks(10);

        // 0x55 with low stop bit, line held low, then 0x33
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        wait_clks(40);
        check("ferr_pulses",   fe_cnt - fe0, 1);
        check("ferr_no_valid", dv_cnt - dv0, 0);
        check("break_busy",    bus_if.busy, 1'b1);
        rx = 1'b1;
        wait_clks(1);
        check("break_busy_sync", bus_if.busy, 1'b1);
        wait_clks(3);
        check("break_idle", bus_if.busy, 1'b0);
        wait_clks(10);
        send_frame(8'h33, 1'b1);
        wait_clks(5);
        check("b33_data",  bus_if.data_out,   8'h33);
        check("b33_valid", bus_if.data_valid, 1'b1);
        bus_if.data_ready = 1'b1;
        wait_clks(1);
        bus_if.data_ready = 1'b0;
        wait_clks(10);

        // 4-clock low glitch on idle line
        dv0 = dv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        wait_clks(4);
        check("glitch_busy", bus_if.busy, 1'b1);
        rx = 1'b1;
        wait_clks(20);
        check("glitch_idle", bus_if.busy, 1'b0);
        check("glitch_no_valid", dv_cnt - dv0, 0);
        check("glitch_no_pulse", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // Back-to-back 0x01, 0x02 with ready pulsed on the 0x02 load cycle
        fall0 = dv_fall;
        send_frame(8'h01, 1'b1);
        n2 = cyc;
        fork
            send_frame(8'h02, 1'b1);
            begin
                wait_clks(LAT - 1);
                check("b2b_first", bus_if.data_out, 8'h01);
                bus_if.data_ready = 1'b1;
                wait_clks(1);
                bus_if.data_ready = 1'b0;
            end
        join
        wait_clks(2);
        check("b2b_second",  bus_if.data_out,   8'h02);
        check("b2b_valid",   bus_if.data_valid, 1'b1);
        check("b2b_no_gap",  dv_fall - fall0,   0);
        check("b2b_ready_cyc", cyc - n2, 162);

        // Reset during bit 4 of a frame while 0x02 is still held
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_clks(16 * 5 + 8);
                rst = 1'b1;
                #1;
                check("rst_valid", bus_if.data_valid, 1'b0);
                check("rst_data",  bus_if.data_out,   8'h00);
                check("rst_busy",  bus_if.busy,       1'b0);
                check("rst_pulses", {bus_if.frame_err, bus_if.overrun}, 2'b00);
            end
        join
        wait_clks(1);
        rst = 1'b0;
        wait_clks(10);
        send_frame(8'hC3, 1'b1);
        wait_clks(5);
        check("c3_data",  bus_if.data_out,   8'hC3);
        check("c3_valid", bus_if.data_valid, 1'b1);
        wait_clks(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
